// File: rtl/csr_regfile_if.sv
// CSR request/response bundle between the execute stage and the CSR file.
// The execute stage drives requests; csr_regfile answers through the csr modport.
`timescale 1ns/1ps
interface csr_if;
    logic        csr_write;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;

    modport csr (
        input  csr_write,
        input  csr_waddr,
        input  csr_wdata,
        input  csr_raddr,
        output csr_rdata
    );

    modport ex (
        output csr_write,
        output csr_waddr,
        output csr_wdata,
        output csr_raddr,
        input  csr_rdata
    );
endinterface

// File: rtl/csr_regfile.sv
// RV32 machine-mode CSR file: trap/status registers and the 64-bit counters.
// Reads are combinational from pre-edge state; all updates happen on the clock edge.
`timescale 1ns/1ps
package common_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

module csr_regfile
    import common_types_pkg::*;
#(
    parameter int unsigned HART_ID     = 0,
    parameter word_t       MTVEC_RESET = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    csr_if.csr    cif,
    input  logic  inst_retire,
    input  logic  trap,
    input  word_t trap_cause,
    input  word_t trap_epc,
    input  word_t trap_tval,
    input  logic  mret,
    input  logic  ext_irq,
    input  logic  timer_irq,
    input  logic  sw_irq,
    output word_t mtvec_o,
    output word_t mepc_o,
    output logic  irq_pending
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam word_t MISA_VAL = 32'h4000_0100;
    localparam word_t MIE_MASK = 32'h0000_0888;
    localparam word_t ALIGN4   = 32'hFFFF_FFFC;

    logic        st_mie;
    logic        st_mpie;
    word_t       mie_q;
    word_t       mtvec_q;
    word_t       mscratch_q;
    word_t       mepc_q;
    word_t       mcause_q;
    word_t       mtval_q;
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    word_t       mip;
    word_t       mstatus_r;
    word_t       rdata;
    word_t       wd;
    logic [11:0] wa;
    logic        wr_en;
    logic        we_mstatus;
    logic        we_mie;
    logic        we_mtvec;
    logic        we_mscratch;
    logic        we_mepc;
    logic        we_mcause;
    logic        we_mtval;
    logic        we_cyc_lo;
    logic        we_cyc_hi;
    logic        we_ins_lo;
    logic        we_ins_hi;
    logic [63:0] cycle_d;
    logic [63:0] instret_d;

    assign mip = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};
    assign mstatus_r = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

    assign irq_pending = st_mie & (|(mie_q & mip));
    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;

    // A trap swallows the whole write; mret only blocks writes to mstatus.
    assign wd          = cif.csr_wdata;
    assign wa          = cif.csr_waddr;
    assign wr_en       = cif.csr_write & ~trap;
    assign we_mstatus  = wr_en & ~mret & (wa == A_MSTATUS);
    assign we_mie      = wr_en & (wa == A_MIE);
    assign we_mtvec    = wr_en & (wa == A_MTVEC);
    assign we_mscratch = wr_en & (wa == A_MSCRATCH);
    assign we_mepc     = wr_en & (wa == A_MEPC);
    assign we_mcause   = wr_en & (wa == A_MCAUSE);
    assign we_mtval    = wr_en & (wa == A_MTVAL);
    assign we_cyc_lo   = wr_en & (wa == A_MCYCLE);
    assign we_cyc_hi   = wr_en & (wa == A_MCYCLEH);
    assign we_ins_lo   = wr_en & (wa == A_MINSTRET);
    assign we_ins_hi   = wr_en & (wa == A_MINSTRETH);

    // The unwritten half keeps the increment (and carry) of the pre-write count.
    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        instret_d = instret_q + {63'b0, inst_retire};
        if (we_cyc_lo) cycle_d[31:0]    = wd;
        if (we_cyc_hi) cycle_d[63:32]   = wd;
        if (we_ins_lo) instret_d[31:0]  = wd;
        if (we_ins_hi) instret_d[63:32] = wd;
    end

    always_comb begin
        rdata = '0;
        unique case (cif.csr_raddr)
            A_MSTATUS:                rdata = mstatus_r;
            A_MISA:                   rdata = MISA_VAL;
            A_MIE:                    rdata = mie_q;
            A_MTVEC:                  rdata = mtvec_q;
            A_MSCRATCH:               rdata = mscratch_q;
            A_MEPC:                   rdata = mepc_q;
            A_MCAUSE:                 rdata = mcause_q;
            A_MTVAL:                  rdata = mtval_q;
            A_MIP:                    rdata = mip;
            A_MCYCLE,    A_CYCLE:     rdata = cycle_q[31:0];
            A_MCYCLEH,   A_CYCLEH:    rdata = cycle_q[63:32];
            A_MINSTRET,  A_INSTRET:   rdata = instret_q[31:0];
            A_MINSTRETH, A_INSTRETH:  rdata = instret_q[63:32];
            A_MHARTID:                rdata = word_t'(HART_ID);
            default:                  rdata = '0;
        endcase
    end

    assign cif.csr_rdata = rdata;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            if (trap) begin
                mepc_q   <= trap_epc & ALIGN4;
                mcause_q <= trap_cause;
                mtval_q  <= trap_tval;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else begin
                if (mret) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end
                unique case (1'b1)
                    we_mstatus: begin
                        st_mie  <= wd[3];
                        st_mpie <= wd[7];
                    end
                    we_mie:      mie_q      <= wd & MIE_MASK;
                    we_mtvec:    mtvec_q    <= {wd[31:2], 1'b0, wd[1:0] == 2'b01};
                    we_mscratch: mscratch_q <= wd;
                    we_mepc:     mepc_q     <= wd & ALIGN4;
                    we_mcause:   mcause_q   <= wd;
                    we_mtval:    mtval_q    <= wd;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed vectors, corner sequences,
// and randomized traffic compared against a behavioural CSR model.
`timescale 1ns/1ps
module tb_csr_regfile;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        inst_retire = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_epc = '0;
    logic [31:0] trap_tval = '0;
    logic        mret = 1'b0;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic        sw_irq = 1'b0;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        irq_pending;

    csr_if cif();

    csr_regfile #(
        .HART_ID(3),
        .MTVEC_RESET(MTVEC_RST)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .cif(cif),
        .inst_retire(inst_retire),
        .trap(trap),
        .trap_cause(trap_cause),
        .trap_epc(trap_epc),
        .trap_tval(trap_tval),
        .mret(mret),
        .ext_irq(ext_irq),
        .timer_irq(timer_irq),
        .sw_irq(sw_irq),
        .mtvec_o(mtvec_o),
        .mepc_o(mepc_o),
        .irq_pending(irq_pending)
    );

    always #50 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model, kept as plain architectural values.
    bit          m_valid = 0;
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;

    function automatic logic [31:0] m_mip();
        return (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0)
             | (sw_irq ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0)
                          | (m_mie ? 32'h8 : 32'h0);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip();
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            12'hF14: return 32'd3;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_irq();
        return m_mie && ((m_mie_reg & m_mip()) != 0);
    endfunction

    task automatic m_step();
        logic [63:0] nc, ni;
        logic [31:0] d;
        if (!nRST) begin
            m_valid = 1;
            m_mie = 0; m_mpie = 0;
            m_mie_reg = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cyc = 0; m_ins = 0;
            return;
        end
        nc = m_cyc + 1;
        ni = m_ins + (inst_retire ? 64'd1 : 64'd0);
        d = cif.csr_wdata;
        if (trap) begin
            m_mepc = trap_epc & ~32'd3;
            m_mcause = trap_cause;
            m_mtval = trap_tval;
            m_mpie = m_mie;
            m_mie = 0;
        end else begin
            if (mret) begin
                m_mie = m_mpie;
                m_mpie = 1;
            end
            if (cif.csr_write) begin
                case (cif.csr_waddr)
                    12'h300: if (!mret) begin m_mie = d[3]; m_mpie = d[7]; end
                    12'h304: m_mie_reg = d & 32'h888;
                    12'h305: m_mtvec = (d & ~32'd3) | ((d % 4 == 1) ? 32'd1 : 32'd0);
                    12'h340: m_mscratch = d;
                    12'h341: m_mepc = d & ~32'd3;
                    12'h342: m_mcause = d;
                    12'h343: m_mtval = d;
                    12'hB00: nc[31:0] = d;
                    12'hB80: nc[63:32] = d;
                    12'hB02: ni[31:0] = d;
                    12'hB82: ni[63:32] = d;
                    default: ;
                endcase
            end
        end
        m_cyc = nc;
        m_ins = ni;
    endtask

    task automatic cyc();
        #1;
        if (m_valid) begin
            chk($sformatf("model rd %h", cif.csr_raddr), cif.csr_rdata,
                m_read(cif.csr_raddr));
            chk("model mtvec_o", mtvec_o, m_mtvec);
            chk("model mepc_o", mepc_o, m_mepc);
            chk("model irq_pending", {31'b0, irq_pending}, {31'b0, m_irq()});
        end
        @(posedge CLK);
        m_step();
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cif.csr_write = 1'b1;
        cif.csr_waddr = a;
        cif.csr_wdata = d;
        cyc();
        cif.csr_write = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp,
                      input string name);
        cif.csr_raddr = a;
        #1;
        chk(name, cif.csr_rdata, exp);
    endtask

    typedef struct {
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    logic [11:0] addrs[$] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
        12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
        12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12,
        12'hF13, 12'hF14, 12'h7C0, 12'h000};

    initial begin
        cif.csr_write = 1'b0;
        cif.csr_waddr = '0;
        cif.csr_wdata = '0;
        cif.csr_raddr = '0;

        nRST = 1'b0;
        cyc();
        cyc();
        nRST = 1'b1;

        rd(12'h300, 32'h0000_1800, "reset mstatus");
        rd(12'h301, 32'h4000_0100, "misa");
        rd(12'hF14, 32'd3, "mhartid");
        rd(12'hB00, 32'd0, "mcycle first");
        chk("reset mtvec_o", mtvec_o, MTVEC_RST);
        chk("reset mepc_o", mepc_o, 32'h0);
        chk("reset irq", {31'b0, irq_pending}, 32'h0);
        cyc();
        rd(12'hB00, 32'd1, "mcycle second");
        cyc();
        rd(12'hB00, 32'd2, "mcycle third");

        vecs.push_back('{12'h305, 32'h8000_0003, 12'h305, 32'h8000_0000, "mtvec mode3"});
        vecs.push_back('{12'h305, 32'h8000_0001, 12'h305, 32'h8000_0001, "mtvec mode1"});
        vecs.push_back('{12'h305, 32'h1234_5676, 12'h305, 32'h1234_5674, "mtvec mode2"});
        vecs.push_back('{12'h341, 32'h1234_5677, 12'h341, 32'h1234_5674, "mepc align"});
        vecs.push_back('{12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, "mie mask"});
        vecs.push_back('{12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, "mscratch"});
        vecs.push_back('{12'h342, 32'h8000_000B, 12'h342, 32'h8000_000B, "mcause"});
        vecs.push_back('{12'h343, 32'hCAFE_F00D, 12'h343, 32'hCAFE_F00D, "mtval"});
        vecs.push_back('{12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, "mstatus ones"});
        vecs.push_back('{12'h300, 32'h0000_0000, 12'h300, 32'h0000_1800, "mstatus zero"});
        vecs.push_back('{12'h301, 32'h0000_0000, 12'h301, 32'h4000_0100, "misa ro"});
        vecs.push_back('{12'h7C0, 32'hFFFF_FFFF, 12'h7C0, 32'h0000_0000, "unmapped"});
        vecs.push_back('{12'hF14, 32'h0000_0000, 12'hF14, 32'd3, "mhartid ro"});
        vecs.push_back('{12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0000_0000, "mip ro"});
        vecs.push_back('{12'hF11, 32'h0000_0001, 12'hF11, 32'h0000_0000, "mvendorid"});

        foreach (vecs[i]) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, vecs[i].exp, vecs[i].name);
        end

        // Read and write of the same address in one cycle.
        wr(12'h340, 32'd11);
        cif.csr_write = 1'b1;
        cif.csr_waddr = 12'h340;
        cif.csr_wdata = 32'd22;
        rd(12'h340, 32'd11, "rw same cycle old");
        cyc();
        cif.csr_write = 1'b0;
        rd(12'h340, 32'd22, "rw same cycle new");

        // Trap with a concurrent write, then mret.
        wr(12'h340, 32'h55);
        wr(12'h300, 32'h8);
        trap = 1'b1;
        trap_cause = 32'h8000_0007;
        trap_epc = 32'h100;
        trap_tval = 32'd5;
        cif.csr_write = 1'b1;
        cif.csr_waddr = 12'h340;
        cif.csr_wdata = 32'd9;
        cyc();
        trap = 1'b0;
        cif.csr_write = 1'b0;
        rd(12'h341, 32'h100, "trap mepc");
        rd(12'h342, 32'h8000_0007, "trap mcause");
        rd(12'h343, 32'd5, "trap mtval");
        rd(12'h300, 32'h1880, "trap mstatus");
        rd(12'h340, 32'h55, "trap drops write");
        chk("trap mepc_o", mepc_o, 32'h100);
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        rd(12'h300, 32'h1888, "mret mstatus");

        wr(12'h300, 32'h80);
        mret = 1'b1;
        cif.csr_write = 1'b1;
        cif.csr_waddr = 12'h300;
        cif.csr_wdata = 32'h0;
        cyc();
        rd(12'h300, 32'h1888, "mret drops mstatus wr");
        cif.csr_waddr = 12'h340;
        cif.csr_wdata = 32'hAA;
        cyc();
        mret = 1'b0;
        cif.csr_write = 1'b0;
        rd(12'h340, 32'hAA, "mret keeps other wr");

        // Trap held for two cycles applies twice.
        trap = 1'b1;
        trap_epc = 32'h203;
        cyc();
        cyc();
        trap = 1'b0;
        rd(12'h300, 32'h1800, "double trap mstatus");
        rd(12'h341, 32'h200, "trap epc align");

        // Counter wrap and write collisions.
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle written");
        rd(12'hB80, 32'h0, "mcycleh before carry");
        cyc();
        rd(12'hB80, 32'd1, "mcycleh carry");
        rd(12'hB00, 32'd0, "mcycle wrapped");
        rd(12'hC80, 32'd1, "cycleh shadow");
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'd5);
        rd(12'hB80, 32'd5, "mcycleh write wins");
        rd(12'hB00, 32'd0, "mcycle incs on hi wr");

        inst_retire = 1'b1;
        wr(12'hB02, 32'd10);
        inst_retire = 1'b0;
        rd(12'hB02, 32'd10, "minstret no +1");
        wr(12'hB82, 32'hFFFF_FFFF);
        wr(12'hB02, 32'hFFFF_FFFF);
        rd(12'hC82, 32'hFFFF_FFFF, "instreth shadow");
        inst_retire = 1'b1;
        cyc();
        inst_retire = 1'b0;
        rd(12'hB02, 32'd0, "minstret wrap lo");
        rd(12'hB82, 32'd0, "minstret wrap hi");

        // Interrupt pending.
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        timer_irq = 1'b1;
        #1;
        chk("irq same cycle", {31'b0, irq_pending}, 32'd1);
        rd(12'h344, 32'h80, "mip timer");
        timer_irq = 1'b0;
        ext_irq = 1'b1;
        #1;
        chk("irq masked ext", {31'b0, irq_pending}, 32'd0);
        ext_irq = 1'b0;
        timer_irq = 1'b1;
        cif.csr_write = 1'b1;
        cif.csr_waddr = 12'h300;
        cif.csr_wdata = 32'h0;
        #1;
        chk("irq before mie clr", {31'b0, irq_pending}, 32'd1);
        cyc();
        cif.csr_write = 1'b0;
        chk("irq after mie clr", {31'b0, irq_pending}, 32'd0);
        timer_irq = 1'b0;

        // Reset beats trap, write and counting.
        wr(12'h340, 32'h77);
        nRST = 1'b0;
        trap = 1'b1;
        cif.csr_write = 1'b1;
        cif.csr_waddr = 12'h340;
        cif.csr_wdata = 32'h1234;
        cyc();
        nRST = 1'b1;
        trap = 1'b0;
        cif.csr_write = 1'b0;
        rd(12'h340, 32'h0, "reset beats write");
        rd(12'h300, 32'h1800, "reset beats trap");
        rd(12'hB00, 32'h0, "reset clears mcycle");
        chk("reset mtvec_o again", mtvec_o, MTVEC_RST);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            nRST = ($urandom_range(0, 199) != 0);
            cif.csr_write = $urandom_range(0, 1) == 1;
            cif.csr_waddr = addrs[$urandom_range(0, addrs.size() - 1)];
            cif.csr_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            cif.csr_raddr = addrs[$urandom_range(0, addrs.size() - 1)];
            trap = $urandom_range(0, 15) == 0;
            trap_cause = $urandom;
            trap_epc = $urandom;
            trap_tval = $urandom;
            mret = $urandom_range(0, 7) == 0;
            inst_retire = $urandom_range(0, 1) == 1;
            ext_irq = $urandom_range(0, 1) == 1;
            timer_irq = $urandom_range(0, 1) == 1;
            sw_irq = $urandom_range(0, 1) == 1;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
